pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage integer pipeline.
- Drives hold and bubble controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves three hazards:
  - load-use data hazard
  - multi-cycle multiply occupying EX
  - taken branch/jump redirect resolved in EX
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- MUL_CYCLES, 4: total EX-stage occupancy of a multiply, in cycles (legal range 1..16).
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- id_rs1  in  5  ID-stage source register 1.
- id_rs2  in  5  ID-stage source register 2.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_valid  in  1  EX holds a real instruction, not a bubble.
- ex_destReg  in  5  EX destination register.
- ex_RegWrite  in  1  EX instruction writes the register file.
- ex_MemToReg  in  1  EX instruction is a load.
- ex_mul  in  1  EX instruction is a multiply.
- ex_take_branch  in  1  EX resolved a taken branch or jump.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_stall  out  1  hold ID/EX.
- idex_flush  out  1  load bubble into ID/EX (drives the register's flush control).
- exmem_flush  out  1  load bubble into EX/MEM.
- mul_busy  out  1  multiply currently holding EX.
- stall_count  out  CNT_W  cycles with pc_stall=1; saturating.
- flush_count  out  CNT_W  taken redirects; saturating.

Behaviour:
- One clock, clk. Reset is synchronous and active-high (reset). While reset=1:
  - all control outputs are 0;
  - FSM goes to IDLE and cnt goes to 0;
  - both counters go to 0.
- Reset in the middle of a multiply abandons the multiply; there is no pending stall after reset drops.
- Control outputs are combinational from the inputs plus registered FSM state. Zero added latency.

Multiply FSM, states IDLE and BUSY, 4-bit down-counter cnt:
- mul_start = IDLE & ex_valid & ex_mul & (MUL_CYCLES>1).
- On mul_start: mul_busy=1 that cycle, state goes to BUSY, cnt is loaded with MUL_CYCLES-2.
- BUSY with cnt!=0: mul_busy=1 and cnt decrements.
- BUSY with cnt==0: mul_busy=0 and state goes to IDLE. ID/EX advances that cycle.
- Net effect: exactly MUL_CYCLES-1 stall cycles per multiply.
- ex_mul is ignored in BUSY, because the held multiply is still in EX.
- Back-to-back multiplies: the next one can start on the cycle immediately after BUSY exits.
- MUL_CYCLES=1: the FSM never leaves IDLE.

Load-use hazard:
- lu = ex_valid & ex_MemToReg & ex_RegWrite & (ex_destReg!=0) & ((id_use_rs1 & id_rs1==ex_destReg) | (id_use_rs2 & id_rs2==ex_destReg)).

Output priority, highest first:
1. Taken branch, when ex_take_branch & ex_valid & !mul_busy:
   - ifid_flush=1, idex_flush=1.
   - No stalls; PC takes the redirect target.
   - lu in the same cycle is ignored, since the ID instruction is squashed.
2. mul_busy:
   - pc_stall=1, ifid_stall=1, idex_stall=1, exmem_flush=1.
   - idex_flush=0; lu is not acted on.
3. lu:
   - pc_stall=1, ifid_stall=1, idex_flush=1.
   - Exactly one cycle: the load moves to MEM next cycle, so lu drops.
4. Otherwise all control outputs are 0.

Invariants:
- A stall and a flush of the same register are never asserted together.
- ex_mul and ex_take_branch are mutually exclusive; this is assertion-checked.
- If both are asserted in IDLE, mul_busy=1 on the mul_start cycle, so the branch is not honoured (priority 2 applies).

Counters:
- stall_count increments on every cycle with pc_stall=1.
- flush_count increments on every cycle with ifid_flush=1.
- Both saturate at all-ones and never wrap.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum {IDLE, BUSY};
  - REG_ZERO = 5'd0;
  - REG_W = 5;
  - MUL_CNT_W = 4.
- One sub-module, mul_seq_fsm: owns the state and cnt and outputs mul_busy.
- Hazard priority logic and the counters live in the top module.

Test Plan:
- Load-use:
  - Stimulus: ex load with ex_destReg=5 and RegWrite=1; ID has id_use_rs2=1, id_rs2=5.
  - Required: pc_stall=ifid_stall=idex_flush=1 for exactly 1 cycle, then 0; stall_count=1.
  - Repeat with ex_destReg=0: no stall.
- Multiply, MUL_CYCLES=4:
  - Stimulus: ex_mul=1 for one instruction.
  - Required: mul_busy, idex_stall and exmem_flush high for 3 consecutive cycles; FSM back in IDLE on the 4th; stall_count=3.
- Back-to-back multiplies:
  - Required: 3 stall cycles, 1 free cycle, 3 stall cycles; stall_count=6.
- Taken branch:
  - Stimulus: ex_take_branch=1, with lu also true in the same cycle.
  - Required: ifid_flush=idex_flush=1, pc_stall=0; flush_count=1.
- Reset mid-multiply:
  - Stimulus: assert reset on the 2nd BUSY cycle.
  - Required: all outputs 0 that cycle and after; counters 0; no residual stall.
- Saturation:
  - Setup: CNT_W=4.
  - Stimulus: 20 stall cycles.
  - Required: stall_count holds at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl_pkg
// Brief   : Shared types and constants for the pipeline hazard controller.
// Revision: 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int REG_W     = 5;
    localparam int MUL_CNT_W = 4;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_t;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl_if
// Brief   : Pipeline-side hazard inputs and stall/flush controls bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipe_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_valid;
    logic [REG_W-1:0] ex_destReg;
    logic             ex_RegWrite;
    logic             ex_MemToReg;
    logic             ex_mul;
    logic             ex_take_branch;

    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_stall;
    logic             idex_flush;
    logic             exmem_flush;
    logic             mul_busy;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    // Pipeline datapath side
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_valid, ex_destReg, ex_RegWrite, ex_MemToReg, ex_mul, ex_take_branch,
        input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush,
        input  mul_busy, stall_count, flush_count
    );

    // Hazard controller side
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_valid, ex_destReg, ex_RegWrite, ex_MemToReg, ex_mul, ex_take_branch,
        output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush,
        output mul_busy, stall_count, flush_count
    );

endinterface : pipe_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_mul_seq.sv
`default_nettype none
// ============================================================================
// Module  : mul_seq_fsm
// Brief   : Tracks a multi-cycle multiply occupying EX and flags mul_busy.
// Revision: 1.0 - initial release
// ============================================================================
module mul_seq_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4
) (
    input  wire  clk,
    input  wire  reset,
    input  logic i_ex_valid,
    input  logic i_ex_mul,
    output logic o_mul_busy
);

    localparam logic c_MUL_MULTI = (MUL_CYCLES > 1);
    localparam logic [MUL_CNT_W-1:0] c_CNT_LOAD =
        (MUL_CYCLES > 1) ? MUL_CNT_W'(MUL_CYCLES - 2) : '0;

    mul_state_t           r_state;
    logic [MUL_CNT_W-1:0] r_cnt;
    logic                 w_mul_start;

    // The start cycle must already stall, so busy is derived from state plus inputs.
    assign w_mul_start = (r_state == IDLE) & i_ex_valid & i_ex_mul & c_MUL_MULTI;
    assign o_mul_busy  = w_mul_start | ((r_state == BUSY) & (r_cnt != '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mul_start) begin
                        r_state <= BUSY;
                        r_cnt   <= c_CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule : mul_seq_fsm
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : Stall/flush sequencer for load-use, multiply and redirect hazards.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 32
) (
    input wire clk,
    input wire reset,
    pipe_hazard_ctrl_if.slave bus
);

    logic             w_mul_busy;
    logic             w_lu;
    logic             w_br;
    logic             w_pc_stall;
    logic             w_ifid_stall;
    logic             w_ifid_flush;
    logic             w_idex_stall;
    logic             w_idex_flush;
    logic             w_exmem_flush;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    mul_seq_fsm #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul_seq (
        .clk        (clk),
        .reset      (reset),
        .i_ex_valid (bus.ex_valid),
        .i_ex_mul   (bus.ex_mul),
        .o_mul_busy (w_mul_busy)
    );

    assign w_lu = bus.ex_valid & bus.ex_MemToReg & bus.ex_RegWrite &
                  (bus.ex_destReg != REG_ZERO) &
                  ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_destReg)) |
                   (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_destReg)));

    // A redirect cannot be honoured while the multiply still owns EX.
    assign w_br = bus.ex_take_branch & bus.ex_valid & ~w_mul_busy;

    always_comb begin
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_stall  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        if (!reset) begin
            if (w_br) begin
                w_ifid_flush = 1'b1;
                w_idex_flush = 1'b1;
            end else if (w_mul_busy) begin
                w_pc_stall    = 1'b1;
                w_ifid_stall  = 1'b1;
                w_idex_stall  = 1'b1;
                w_exmem_flush = 1'b1;
            end else if (w_lu) begin
                w_pc_stall   = 1'b1;
                w_ifid_stall = 1'b1;
                w_idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_pc_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_ifid_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign bus.pc_stall    = w_pc_stall;
    assign bus.ifid_stall  = w_ifid_stall;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_stall  = w_idex_stall;
    assign bus.idex_flush  = w_idex_flush;
    assign bus.exmem_flush = w_exmem_flush;
    assign bus.mul_busy    = w_mul_busy & ~reset;
    assign bus.stall_count = r_stall_cnt;
    assign bus.flush_count = r_flush_cnt;

    a_mul_br_excl: assert property (@(posedge clk) disable iff (reset)
        !(bus.ex_valid && bus.ex_mul && bus.ex_take_branch));

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_hazard_ctrl
// Brief   : Directed + randomized check of pipe_hazard_ctrl against a cycle model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int c_MUL  = 4;
    localparam int c_CNTW = 4;
    localparam int c_CMAX = (1 << c_CNTW) - 1;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    // Model state: remaining EX occupancy of the current multiply, and event counts
    int   m_rem;
    int   m_stall;
    int   m_flush;
    logic e_pc_stall, e_ifid_stall, e_ifid_flush, e_idex_stall, e_idex_flush;
    logic e_exmem_flush, e_mul_busy;

    pipe_hazard_ctrl_if #(.CNT_W(c_CNTW)) bus ();

    pipe_hazard_ctrl #(
        .MUL_CYCLES (c_MUL),
        .CNT_W      (c_CNTW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_eval();
        logic lu;
        logic br;
        e_mul_busy = 1'b0;
        if (!reset) begin
            if (m_rem == 0) e_mul_busy = bus.ex_valid & bus.ex_mul & (c_MUL > 1);
            else            e_mul_busy = (m_rem > 1);
        end
        lu = bus.ex_valid && bus.ex_MemToReg && bus.ex_RegWrite && (bus.ex_destReg != 0) &&
             ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_destReg) ||
              (bus.id_use_rs2 && bus.id_rs2 == bus.ex_destReg));
        br = bus.ex_valid && bus.ex_take_branch && !e_mul_busy;
        {e_pc_stall, e_ifid_stall, e_ifid_flush, e_idex_stall, e_idex_flush, e_exmem_flush} = '0;
        if (!reset) begin
            if (br) begin
                e_ifid_flush = 1'b1; e_idex_flush = 1'b1;
            end else if (e_mul_busy) begin
                e_pc_stall = 1'b1; e_ifid_stall = 1'b1; e_idex_stall = 1'b1; e_exmem_flush = 1'b1;
            end else if (lu) begin
                e_pc_stall = 1'b1; e_ifid_stall = 1'b1; e_idex_flush = 1'b1;
            end
        end
    endtask

    // Drive one cycle's inputs, then compare every output against the model.
    task automatic apply(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic v, input logic [4:0] dst,
                         input logic rw, input logic m2r, input logic mul, input logic br);
        reset              = rst;
        bus.id_rs1         = rs1;
        bus.id_rs2         = rs2;
        bus.id_use_rs1     = u1;
        bus.id_use_rs2     = u2;
        bus.ex_valid       = v;
        bus.ex_destReg     = dst;
        bus.ex_RegWrite    = rw;
        bus.ex_MemToReg    = m2r;
        bus.ex_mul         = mul;
        bus.ex_take_branch = br;
        #3;
        model_eval();
        chk("pc_stall",    32'(bus.pc_stall),    32'(e_pc_stall));
        chk("ifid_stall",  32'(bus.ifid_stall),  32'(e_ifid_stall));
        chk("ifid_flush",  32'(bus.ifid_flush),  32'(e_ifid_flush));
        chk("idex_stall",  32'(bus.idex_stall),  32'(e_idex_stall));
        chk("idex_flush",  32'(bus.idex_flush),  32'(e_idex_flush));
        chk("exmem_flush", 32'(bus.exmem_flush), 32'(e_exmem_flush));
        chk("mul_busy",    32'(bus.mul_busy),    32'(e_mul_busy));
        chk("stall_count", 32'(bus.stall_count), 32'(m_stall));
        chk("flush_count", 32'(bus.flush_count), 32'(m_flush));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_rem = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (m_rem == 0) begin
                if (e_mul_busy) m_rem = c_MUL - 1;
            end else begin
                m_rem--;
            end
            if (e_pc_stall && m_stall < c_CMAX) m_stall++;
            if (e_ifid_flush && m_flush < c_CMAX) m_flush++;
        end
        #1;
    endtask

    task automatic idle_cycle(input logic rst);
        apply(rst, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic mul_cycle();
        apply(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        n_total = 0; n_bad = 0;
        m_rem = 0; m_stall = 0; m_flush = 0;
        #1;

        idle_cycle(1'b1);
        idle_cycle(1'b1);
        chk("rst_stall_count", 32'(bus.stall_count), 32'd0);

        // Load-use on rs2, then load moves on
        apply(1'b0, 5'd9, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lu_pc_stall", 32'(bus.pc_stall), 32'd1);
        chk("lu_idex_flush", 32'(bus.idex_flush), 32'd1);
        tick();
        apply(1'b0, 5'd9, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_one_cycle", 32'(bus.pc_stall), 32'd0);
        tick();
        chk("lu_stall_count", 32'(bus.stall_count), 32'd1);
        apply(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lu_r0_no_stall", 32'(bus.pc_stall), 32'd0);
        tick();

        // Single multiply: 3 busy cycles then free
        idle_cycle(1'b1);
        for (int i = 0; i < 4; i++) begin
            mul_cycle();
            chk($sformatf("mul_busy_c%0d", i), 32'(bus.mul_busy), (i < 3) ? 32'd1 : 32'd0);
            chk($sformatf("mul_idex_stall_c%0d", i), 32'(bus.idex_stall), (i < 3) ? 32'd1 : 32'd0);
            tick();
        end
        idle_cycle(1'b0);
        chk("mul_stall_count", 32'(bus.stall_count), 32'd3);

        // Back-to-back multiplies: 3 stall, 1 free, 3 stall, 1 free
        idle_cycle(1'b1);
        for (int i = 0; i < 8; i++) begin
            mul_cycle();
            chk($sformatf("b2b_busy_c%0d", i), 32'(bus.mul_busy),
                (i == 3 || i == 7) ? 32'd0 : 32'd1);
            tick();
        end
        chk("b2b_stall_count", 32'(bus.stall_count), 32'd6);

        // Taken branch overriding a simultaneous load-use
        idle_cycle(1'b1);
        apply(1'b0, 5'd7, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("br_ifid_flush", 32'(bus.ifid_flush), 32'd1);
        chk("br_idex_flush", 32'(bus.idex_flush), 32'd1);
        chk("br_pc_stall", 32'(bus.pc_stall), 32'd0);
        tick();
        chk("br_flush_count", 32'(bus.flush_count), 32'd1);

        // Reset asserted on the second busy cycle of a multiply
        idle_cycle(1'b1);
        mul_cycle();
        tick();
        apply(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rstmul_busy", 32'(bus.mul_busy), 32'd0);
        chk("rstmul_pc_stall", 32'(bus.pc_stall), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            idle_cycle(1'b0);
            chk("rstmul_no_residual", 32'(bus.pc_stall | bus.mul_busy), 32'd0);
        end
        chk("rstmul_counts", 32'({bus.stall_count, bus.flush_count}), 32'd0);

        // Saturation: 20 load-use stall cycles on a 4-bit counter
        idle_cycle(1'b1);
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk("sat_stall_count", 32'(bus.stall_count), 32'd15);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            int k;
            k = int'($urandom_range(0, 5));
            apply(($urandom_range(0, 39) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 5) != 0),
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  (k <= 1), (k == 2));
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
